// File: rtl/usb_buffer_pkg.sv
// Shared sizing and byte type for the USB endpoint data buffer.
package usb_buffer_pkg;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int OCC_W  = ADDR_W + 1;

  typedef logic [7:0] byte_t;

endpackage : usb_buffer_pkg

// File: rtl/buffer_pointer.sv
// Wrapping ADDR_W-bit index counter with synchronous reset, clear and increment-enable.
module buffer_pointer
  import usb_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ADDR_W'(1);  // natural wrap DEPTH-1 -> 0 since DEPTH is a power of two
    end
  end

endmodule : buffer_pointer

// File: rtl/data_buffer.sv
// Shared 64-byte show-ahead FIFO between the AHB register stage and the USB RX/TX path.
module data_buffer
  import usb_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             store_tx_data,
  input  byte_t            tx_data,
  input  logic             get_rx_data,
  output byte_t            rx_data,
  input  logic             store_rx_packet_data,
  input  byte_t            rx_packet_data,
  input  logic             get_tx_packet_data,
  output byte_t            tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             buffer_error
);

  byte_t              mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]   occupancy;
  logic               error_q;

  logic  push_req, pop_req, full, empty;
  logic  do_push, do_pop, error_next;
  byte_t wr_byte, head;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    push_req   = store_tx_data | store_rx_packet_data;
    pop_req    = get_rx_data | get_tx_packet_data;
    full       = (occupancy == OCC_W'(DEPTH));
    empty      = (occupancy == '0);
    wr_byte    = store_tx_data ? tx_data : rx_packet_data;
    // A full buffer accepts a push only when a pop frees the head slot in the same cycle.
    do_push    = push_req & (~full | pop_req);
    do_pop     = pop_req & ~empty;
    error_next = (store_tx_data & store_rx_packet_data)
               | (push_req & full & ~pop_req)
               | (pop_req & empty);
    head       = empty ? 8'h00 : mem[rd_ptr];
  end

  buffer_pointer u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (do_push),
    .ptr   (wr_ptr)
  );

  buffer_pointer u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (do_pop),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      occupancy <= '0;
      error_q   <= 1'b0;
    end else begin
      error_q <= error_next;
      unique case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) begin
      mem[wr_ptr] <= wr_byte;
    end
  end

  assign rx_data          = head;
  assign tx_packet_data   = head;
  assign buffer_occupancy = occupancy;
  assign buffer_error     = error_q;

endmodule : data_buffer

// File: tb/tb_data_buffer.sv
// Self-checking bench for data_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_data_buffer;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst, clear;
  logic       store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data;
  logic [7:0] tx_data, rx_packet_data, rx_data, tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       buffer_error;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain byte queue plus the expected error flag.
  logic [7:0] model_q[$];
  logic       exp_err = 1'b0;

  data_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .clear                (clear),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .buffer_error         (buffer_error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_head();
    return (model_q.size() > 0) ? model_q[0] : 8'h00;
  endfunction

  // Apply the current strobes to the model, clock one edge, then drop all strobes.
  task automatic tick();
    bit push, pop, was_full, was_empty;
    if (rst || clear) begin
      model_q.delete();
      exp_err = 1'b0;
    end else begin
      push      = store_tx_data | store_rx_packet_data;
      pop       = get_rx_data | get_tx_packet_data;
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      exp_err   = store_tx_data & store_rx_packet_data;
      if (pop) begin
        if (was_empty) exp_err = 1'b1;
        else void'(model_q.pop_front());
      end
      if (push) begin
        if (was_full && !pop) exp_err = 1'b1;
        else model_q.push_back(store_tx_data ? tx_data : rx_packet_data);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; clear = 1'b0;
    store_tx_data = 1'b0; store_rx_packet_data = 1'b0;
    get_rx_data = 1'b0; get_tx_packet_data = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; store_tx_data = 1'b0; store_rx_packet_data = 1'b0;
    get_rx_data = 1'b0; get_tx_packet_data = 1'b0; tx_data = '0; rx_packet_data = '0;
    @(negedge clk);
    rst = 1'b1; tick();
    checks++; if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", buffer_occupancy); end
    checks++; if (buffer_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", buffer_error); end
    checks++; if (rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin errors++; $display("FAIL reset_head got %h/%h exp 00", rx_data, tx_packet_data); end
  endtask

  task automatic test_push_pop_basic();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      store_tx_data = 1'b1; tx_data = vals[i]; tick();
      checks++; if (buffer_occupancy !== 7'(i + 1)) begin errors++; $display("FAIL push_occ[%0d] got %0d exp %0d", i, buffer_occupancy, i + 1); end
      checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL push_head[%0d] got %h exp 11", i, rx_data); end
    end
    for (int i = 0; i < 3; i++) begin
      get_tx_packet_data = 1'b1;
      checks++; if (tx_packet_data !== vals[i]) begin errors++; $display("FAIL pop_data[%0d] got %h exp %h", i, tx_packet_data, vals[i]); end
      tick();
    end
    checks++; if (buffer_occupancy !== 7'd0 || rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
      errors++; $display("FAIL drained occ=%0d rx=%h tx=%h exp 0/00/00", buffer_occupancy, rx_data, tx_packet_data); end
    get_tx_packet_data = 1'b1; tick();
    checks++; if (buffer_error !== 1'b1 || buffer_occupancy !== 7'd0) begin
      errors++; $display("FAIL underflow err=%b occ=%0d exp 1/0", buffer_error, buffer_occupancy); end
    tick();
    checks++; if (buffer_error !== 1'b0) begin errors++; $display("FAIL underflow_pulse got %b exp 0", buffer_error); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < DEPTH; i++) begin
      store_rx_packet_data = 1'b1; rx_packet_data = 8'(i); tick();
    end
    checks++; if (buffer_occupancy !== 7'd64 || buffer_error !== 1'b0) begin
      errors++; $display("FAIL full occ=%0d err=%b exp 64/0", buffer_occupancy, buffer_error); end
    store_rx_packet_data = 1'b1; rx_packet_data = 8'hEE; tick();
    checks++; if (buffer_error !== 1'b1 || buffer_occupancy !== 7'd64 || rx_data !== 8'h00) begin
      errors++; $display("FAIL overflow err=%b occ=%0d head=%h exp 1/64/00", buffer_error, buffer_occupancy, rx_data); end
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h40; get_rx_data = 1'b1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL full_pushpop_head got %h exp 00", rx_data); end
    tick();
    checks++; if (buffer_occupancy !== 7'd64 || rx_data !== 8'h01 || buffer_error !== 1'b0) begin
      errors++; $display("FAIL full_pushpop occ=%0d head=%h err=%b exp 64/01/0", buffer_occupancy, rx_data, buffer_error); end
    for (int i = 1; i <= DEPTH; i++) begin
      get_rx_data = 1'b1;
      checks++; if (rx_data !== 8'(i)) begin errors++; $display("FAIL wrap_order[%0d] got %h exp %h", i, rx_data, 8'(i)); end
      tick();
    end
    checks++; if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL wrap_empty got %0d exp 0", buffer_occupancy); end
  endtask

  task automatic test_collision();
    store_tx_data = 1'b1; tx_data = 8'hAA; store_rx_packet_data = 1'b1; rx_packet_data = 8'h55; tick();
    checks++; if (buffer_occupancy !== 7'd1 || rx_data !== 8'hAA || buffer_error !== 1'b1) begin
      errors++; $display("FAIL collision occ=%0d head=%h err=%b exp 1/aa/1", buffer_occupancy, rx_data, buffer_error); end
    get_rx_data = 1'b1; get_tx_packet_data = 1'b1; tick();
    checks++; if (buffer_occupancy !== 7'd0 || buffer_error !== 1'b0) begin
      errors++; $display("FAIL dual_pop occ=%0d err=%b exp 0/0", buffer_occupancy, buffer_error); end
    store_tx_data = 1'b1; tx_data = 8'h3C; get_rx_data = 1'b1; tick();
    checks++; if (buffer_occupancy !== 7'd1 || rx_data !== 8'h3C || buffer_error !== 1'b1) begin
      errors++; $display("FAIL empty_pushpop occ=%0d head=%h err=%b exp 1/3c/1", buffer_occupancy, rx_data, buffer_error); end
    get_rx_data = 1'b1; tick();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 10; i++) begin
      store_tx_data = 1'b1; tx_data = 8'($urandom); tick();
    end
    clear = 1'b1; store_tx_data = 1'b1; tx_data = 8'h99; get_rx_data = 1'b1; tick();
    checks++; if (buffer_occupancy !== 7'd0 || buffer_error !== 1'b0 || rx_data !== 8'h00) begin
      errors++; $display("FAIL clear occ=%0d err=%b head=%h exp 0/0/00", buffer_occupancy, buffer_error, rx_data); end
    store_tx_data = 1'b1; tx_data = 8'h77; tick();
    checks++; if (rx_data !== 8'h77 || buffer_occupancy !== 7'd1) begin
      errors++; $display("FAIL post_clear head=%h occ=%0d exp 77/1", rx_data, buffer_occupancy); end
    get_rx_data = 1'b1; tick();
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 20; i++) begin
      store_rx_packet_data = 1'b1; rx_packet_data = 8'($urandom); tick();
    end
    checks++; if (buffer_occupancy !== 7'd20) begin errors++; $display("FAIL pre_rst occ got %0d exp 20", buffer_occupancy); end
    rst = 1'b1; store_tx_data = 1'b1; tx_data = 8'hC3; get_rx_data = 1'b1; tick();
    checks++; if (buffer_occupancy !== 7'd0 || buffer_error !== 1'b0) begin
      errors++; $display("FAIL mid_rst occ=%0d err=%b exp 0/0", buffer_occupancy, buffer_error); end
    store_tx_data = 1'b1; tx_data = 8'h5A; tick();
    checks++; if (rx_data !== 8'h5A || buffer_occupancy !== 7'd1) begin
      errors++; $display("FAIL post_rst head=%h occ=%0d exp 5a/1", rx_data, buffer_occupancy); end
    get_tx_packet_data = 1'b1; tick();
    checks++; if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL post_rst_pop occ got %0d exp 0", buffer_occupancy); end
  endtask

  task automatic test_random();
    int push_bias;
    for (int n = 0; n < 3000; n++) begin
      push_bias            = ((n / 300) % 2 == 0) ? 70 : 30;  // alternate fill-heavy and drain-heavy phases
      store_tx_data        = ($urandom_range(99) < push_bias);
      store_rx_packet_data = ($urandom_range(99) < 15);
      get_rx_data          = ($urandom_range(99) < 100 - push_bias);
      get_tx_packet_data   = ($urandom_range(99) < 15);
      clear                = ($urandom_range(999) < 3);
      tx_data              = 8'($urandom);
      rx_packet_data       = 8'($urandom);
      checks++; if (rx_data !== exp_head() || tx_packet_data !== exp_head()) begin
        errors++; $display("FAIL rand_head[%0d] got %h/%h exp %h", n, rx_data, tx_packet_data, exp_head()); end
      tick();
      checks++; if (int'(buffer_occupancy) !== model_q.size()) begin
        errors++; $display("FAIL rand_occ[%0d] got %0d exp %0d", n, buffer_occupancy, model_q.size()); end
      checks++; if (buffer_error !== exp_err) begin
        errors++; $display("FAIL rand_err[%0d] got %b exp %b", n, buffer_error, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop_basic();
    test_fill_wrap();
    test_collision();
    test_clear();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_data_buffer

// File: doc/data_buffer.md
Name: data_buffer

Overview:
- Shared 64-byte byte-wide FIFO in the USB endpoint datapath of the AHB-lite slave.
- Directly downstream of the AHB value/register stage, which pushes via store_tx_data/tx_data, pops via get_rx_data/rx_data, flushes via clear, and reads buffer_occupancy.
- On the other side, the USB RX decoder pushes received payload bytes and the USB TX encoder pops bytes to transmit.
- Single storage array; at most one push and one pop per cycle.

Parameters:
DEPTH, 64, number of byte entries (power of two)
ADDR_W, 6, log2(DEPTH); pointer index width
OCC_W, 7, ADDR_W+1; occupancy width (0..DEPTH)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
clear  input  1  flush request from register stage
store_tx_data  input  1  AHB-side push strobe
tx_data  input  8  AHB-side push byte
get_rx_data  input  1  AHB-side pop strobe
rx_data  output  8  head byte presented to AHB side (show-ahead)
store_rx_packet_data  input  1  USB RX push strobe
rx_packet_data  input  8  USB RX push byte
get_tx_packet_data  input  1  USB TX pop strobe
tx_packet_data  output  8  head byte presented to USB TX (show-ahead)
buffer_occupancy  output  OCC_W  bytes currently stored
buffer_error  output  1  one-cycle pulse on overflow, underflow or push collision

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_ptr, rd_ptr and occupancy go to 0; buffer_error goes to 0.
  - Memory contents are not reset.
  - All strobes that cycle are ignored.
- Pointers:
  - ADDR_W bits, increment by 1, wrap DEPTH-1 -> 0.
  - Full/empty are taken from the occupancy register only (occupancy==DEPTH is full, occupancy==0 is empty), never from pointer compare.
- Push request:
  - push_req = store_tx_data | store_rx_packet_data.
  - If both strobes are high, the tx_data byte is stored, the rx_packet_data byte is dropped, and buffer_error pulses.
- Pop request:
  - pop_req = get_rx_data | get_tx_packet_data.
  - If both strobes are high, exactly one entry is popped.
  - Both sinks see the same head byte; no error.
- Show-ahead read path:
  - rx_data = tx_packet_data = mem[rd_ptr] combinationally when occupancy>0; otherwise 8'h00.
  - A sink samples the byte in the same cycle it asserts its pop strobe.
  - The pop takes effect at the next edge.
- Push write: mem[wr_ptr] <= byte and wr_ptr++ at the edge. The byte becomes visible at the head one cycle later at the earliest.
- Latency: occupancy and all pointers are registered; buffer_occupancy reflects a push/pop in the cycle after the strobe.
- Priority order: rst > clear > push/pop.
  - clear=1: pointers and occupancy go to 0 at the edge; push/pop strobes that cycle are discarded; no buffer_error.
- Boundary cases:
  - Push when full, no pop: byte dropped, state unchanged, buffer_error pulses.
  - Push+pop when full: both performed, occupancy stays DEPTH.
  - Pop when empty, no push: no pointer change, outputs 8'h00, buffer_error pulses.
  - Push+pop when empty: push performed, pop ignored, occupancy becomes 1, buffer_error pulses.
  - Push+pop otherwise: both performed, occupancy unchanged.
- buffer_error is registered: it is asserted the cycle after the offending strobe, for one cycle only.
- Width rule: occupancy arithmetic is done in OCC_W bits; +1 and -1 are mutually exclusive per cycle except for the simultaneous push+pop case, which nets zero.

Decomposition:
- Shared package usb_buffer_pkg holds DEPTH, ADDR_W, OCC_W and a typedef for the byte type.
- One natural sub-module, buffer_pointer: ADDR_W-bit wrapping counter with sync reset, clear and increment-enable. It is instantiated twice (write pointer, read pointer).
- Storage array, occupancy counter and error logic stay in data_buffer.

Test Plan:
- Reset, then push 0x11,0x22,0x33 via store_tx_data on consecutive cycles -> buffer_occupancy 1,2,3 on following cycles; rx_data=0x11 once occupancy>=1.
- Pop three times with get_tx_packet_data -> tx_packet_data 0x11,0x22,0x33 in pop cycles, occupancy back to 0, outputs 8'h00; fourth pop -> buffer_error single pulse, occupancy stays 0.
- Fill 64 bytes (0x00..0x3F) via store_rx_packet_data -> occupancy 64. Further push -> dropped, buffer_error pulse. Then push+pop same cycle -> occupancy 64, head 0x01 next cycle. Drain -> data order preserved across pointer wrap.
- Same cycle store_tx_data=1 (0xAA) and store_rx_packet_data=1 (0x55) on empty buffer -> occupancy 1, head 0xAA, buffer_error pulse.
- Occupancy 10, assert clear together with a push and a pop -> next cycle occupancy 0, no buffer_error, then push 0x77 -> head 0x77.
- Assert rst mid-fill at occupancy 20 with push strobe high -> occupancy 0 and buffer_error 0 next cycle; subsequent push/pop works normally.
